// File: rtl/uart_monitor.sv
// uart_monitor: passive 8N1 receiver on a UART pad with byte strobe, framing-error pulse and character count
module uart_monitor #(
  parameter int BAUD_DIV = 868,
  parameter bit PRINT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        uart_sin,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        busy,
  output logic [31:0] char_cnt
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic [31:0]   char_cnt_q, char_cnt_d;
  logic          sin_m_q, sin_s_q;
  logic          expire;
  assign expire = cnt_q == CW'(1);
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    char_cnt_d  = char_cnt_q;
    case (state_q)
      IDLE: if (!sin_s_q) begin
        state_d = START;
        cnt_d   = HALF;
      end
      START: if (expire) begin
        state_d = sin_s_q ? IDLE : DATA;
        cnt_d   = sin_s_q ? '0 : FULL;
        idx_d   = 3'd0;
      end
      DATA: if (expire) begin
        shift_d = {sin_s_q, shift_q[7:1]};
        cnt_d   = FULL;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (expire) begin
        cnt_d       = '0;
        state_d     = sin_s_q ? IDLE : BREAK;
        rx_data_d   = sin_s_q ? shift_q : rx_data_q;
        rx_valid_d  = sin_s_q;
        frame_err_d = !sin_s_q;
        char_cnt_d  = sin_s_q ? char_cnt_q + 32'd1 : char_cnt_q;
      end
      BREAK: state_d = sin_s_q ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      char_cnt_q  <= 32'd0;
      sin_m_q     <= 1'b1;
      sin_s_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      char_cnt_q  <= char_cnt_d;
      sin_m_q     <= uart_sin;
      sin_s_q     <= sin_m_q;
    end
  end
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = state_q != IDLE;
  assign char_cnt  = char_cnt_q;
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (PRINT_EN && rx_valid_q) $write("%c", rx_data_q);
  end
`endif
endmodule

// File: tb/tb_uart_monitor.sv
// tb_uart_monitor: scoreboard bench for uart_monitor at BAUD_DIV=16
module tb_uart_monitor;
  localparam int BD = 16;
  localparam int LAT = 2 + BD / 2 + 9 * BD + 1;
  logic        clk = 1'b0;
  logic        rst_b;
  logic        uart_sin;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, busy;
  logic [31:0] char_cnt;
  typedef struct {
    logic [7:0] data;
    int         c0;
  } exp_t;
  exp_t        sb[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          fe_seen = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [7:0]  last_good = 8'd0;
  uart_monitor #(.BAUD_DIV(BD), .PRINT_EN(1'b1)) dut (
    .clk(clk), .rst_b(rst_b), .uart_sin(uart_sin), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy), .char_cnt(char_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic drive_bit(input logic v);
    uart_sin = v;
    repeat (BD) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) sb.push_back('{data: b, c0: cyc});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask
  task automatic idle(input int n);
    uart_sin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_data"}, 32'(rx_data), 32'h0);
    check({tag, "_valid"}, 32'(rx_valid), 32'h0);
    check({tag, "_ferr"}, 32'(frame_err), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_cnt"}, char_cnt, 32'h0);
  endtask
  always @(negedge clk) begin
    if (rst_b === 1'b1) begin
      if (rx_valid || frame_err) check("excl", 32'(rx_valid & frame_err), 32'h0);
      if (rx_valid) begin
        check("sb_nonempty", 32'(sb.size() > 0), 32'h1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          exp_cnt = exp_cnt + 32'd1;
          last_good = e.data;
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("latency", 32'(cyc - e.c0), 32'(LAT));
          check("char_cnt", char_cnt, exp_cnt);
        end
      end
      if (frame_err) begin
        fe_seen++;
        check("ferr_data", 32'(rx_data), 32'(last_good));
        check("ferr_cnt", char_cnt, exp_cnt);
      end
    end
  end
  initial begin
    rst_b = 1'b0;
    uart_sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle(20);
    send_byte(8'h41, 1'b1);
    idle(20);
    begin
      uart_sin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      uart_sin = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_hi", 32'(busy), 32'h1);
      @(posedge clk);
      @(negedge clk);
      check("glitch_busy_lo", 32'(busy), 32'h0);
      #1;
    end
    idle(20);
    send_byte(8'h55, 1'b0);
    uart_sin = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("break_busy", 32'(busy), 32'h1);
    check("break_data", 32'(rx_data), 32'h41);
    @(posedge clk);
    #1;
    uart_sin = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("break_exit", 32'(busy), 32'h0);
    #1;
    idle(20);
    send_byte(8'h48, 1'b1);
    send_byte(8'h69, 1'b1);
    idle(20);
    check("cnt_hi", char_cnt, 32'd3);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0 ^ (8'h7E >> i) & 1'b1);
    uart_sin = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst_b = 1'b0;
    exp_cnt = 32'd0;
    last_good = 8'd0;
    check_reset_outputs("midrst");
    repeat (4) @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle(40);
    send_byte(8'h0A, 1'b1);
    idle(20);
    check("cnt_after_rst", char_cnt, 32'd1);
    force dut.char_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.char_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    idle(4);
    send_byte(8'h5A, 1'b1);
    idle(20);
    check("cnt_wrap", char_cnt, 32'h0);
    check("ferr_total", 32'(fe_seen), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $write("\n");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
